// File: rtl/writeback_unit_pkg.sv
// Shared RISC-V decode constants and writeback FSM state type.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } wb_state_t;

endpackage

// File: rtl/writeback_unit_load_align.sv
// Combinational load aligner: picks the addressed field out of a naturally
// aligned memory word, extends it, and flags misaligned or illegal accesses.
module load_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  word_i,
    input  logic [OFF_W-1:0] offset_i,
    input  logic [2:0]       funct3_i,
    output logic [XLEN-1:0]  data_o,
    output logic             misaligned_o,
    output logic             illegal_o
);

    // Field masks built by shifting so that the word mask is all-ones on RV32.
    localparam logic [XLEN-1:0] MASK_B = ~({XLEN{1'b1}} << 8);
    localparam logic [XLEN-1:0] MASK_H = ~({XLEN{1'b1}} << 16);
    localparam logic [XLEN-1:0] MASK_W = ~({XLEN{1'b1}} << 32);

    logic [XLEN-1:0] field;

    assign field = word_i >> {offset_i, 3'b000};

    function automatic logic [XLEN-1:0] extend_field(
        input logic [XLEN-1:0] value,
        input logic [XLEN-1:0] mask,
        input logic            sign
    );
        return sign ? (value | ~mask) : (value & mask);
    endfunction

    always_comb begin
        data_o       = '0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = extend_field(field, MASK_B, field[7]);
            F3_LBU: data_o = extend_field(field, MASK_B, 1'b0);
            F3_LH: begin
                data_o       = extend_field(field, MASK_H, field[15]);
                misaligned_o = offset_i[0];
            end
            F3_LHU: begin
                data_o       = extend_field(field, MASK_H, 1'b0);
                misaligned_o = offset_i[0];
            end
            F3_LW: begin
                data_o       = extend_field(field, MASK_W, field[31]);
                misaligned_o = |offset_i[1:0];
            end
            F3_LWU: begin
                if (XLEN == 64) begin
                    data_o       = extend_field(field, MASK_W, 1'b0);
                    misaligned_o = |offset_i[1:0];
                end else begin
                    illegal_o = 1'b1;
                end
            end
            F3_LD: begin
                if (XLEN == 64) begin
                    data_o       = field;
                    misaligned_o = |offset_i;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// RV32/RV64 writeback stage: result selection, load alignment with late-data
// stall, registered register-file write, same-cycle bypass, retire counter.
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             flush_i,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  alu_result_i,
    input  logic [XLEN-1:0]  mem_data_i,
    input  logic             mem_valid_i,
    output logic [4:0]       sel_rd_o,
    output logic             we_o,
    output logic [XLEN-1:0]  data_o,
    output logic             bypass_valid_o,
    output logic [4:0]       bypass_rd_o,
    output logic [XLEN-1:0]  bypass_data_o,
    output logic             misaligned_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retire_count_o
);

    localparam int OFF_W = $clog2(XLEN / 8);

    wb_state_t        state_q, state_d;
    logic [4:0]       rd_q, rd_d;
    logic [2:0]       f3_q, f3_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic             we_q;
    logic [4:0]       sel_rd_q;
    logic [XLEN-1:0]  data_q;
    logic             misaligned_q, misaligned_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retire_count_q, retire_count_d;

    logic             has_result;
    logic [4:0]       res_rd;
    logic [XLEN-1:0]  res_data;
    logic             retire;

    logic [2:0]       align_f3;
    logic [OFF_W-1:0] align_off;
    logic [XLEN-1:0]  align_data;
    logic             align_mis;
    logic             align_ill;

    // While waiting, the aligner must see the fields latched at accept time.
    assign align_f3  = (state_q == IDLE) ? instr_i[14:12] : f3_q;
    assign align_off = (state_q == IDLE) ? alu_result_i[OFF_W-1:0] : off_q;

    load_align #(.XLEN(XLEN)) u_align (
        .word_i       (mem_data_i),
        .offset_i     (align_off),
        .funct3_i     (align_f3),
        .data_o       (align_data),
        .misaligned_o (align_mis),
        .illegal_o    (align_ill)
    );

    assign ready_o = (state_q == IDLE);

    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        f3_d         = f3_q;
        off_d        = off_q;
        has_result   = 1'b0;
        res_rd       = '0;
        res_data     = '0;
        retire       = 1'b0;
        misaligned_d = 1'b0;
        illegal_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    case (instr_i[6:0])
                        OPC_LOAD: begin
                            if (align_ill) begin
                                illegal_d = 1'b1;
                            end else if (mem_valid_i) begin
                                if (align_mis) begin
                                    misaligned_d = 1'b1;
                                end else begin
                                    retire     = 1'b1;
                                    has_result = 1'b1;
                                    res_rd     = instr_i[11:7];
                                    res_data   = align_data;
                                end
                            end else begin
                                state_d = WAIT_LOAD;
                                rd_d    = instr_i[11:7];
                                f3_d    = instr_i[14:12];
                                off_d   = alu_result_i[OFF_W-1:0];
                            end
                        end
                        OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                            retire     = 1'b1;
                            has_result = 1'b1;
                            res_rd     = instr_i[11:7];
                            res_data   = alu_result_i;
                        end
                        OPC_JAL, OPC_JALR: begin
                            retire     = 1'b1;
                            has_result = 1'b1;
                            res_rd     = instr_i[11:7];
                            res_data   = pc_i + XLEN'(4);
                        end
                        default: retire = 1'b1;
                    endcase
                end
            end
            WAIT_LOAD: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (mem_valid_i) begin
                    state_d = IDLE;
                    if (align_mis) begin
                        misaligned_d = 1'b1;
                    end else begin
                        retire     = 1'b1;
                        has_result = 1'b1;
                        res_rd     = rd_q;
                        res_data   = align_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        bypass_valid_o = has_result && (res_rd != 5'd0);
        bypass_rd_o    = bypass_valid_o ? res_rd : 5'd0;
        bypass_data_o  = bypass_valid_o ? res_data : '0;
        retire_count_d = retire ? retire_count_q + CNT_W'(1) : retire_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rd_q           <= '0;
            f3_q           <= '0;
            off_q          <= '0;
            we_q           <= 1'b0;
            sel_rd_q       <= '0;
            data_q         <= '0;
            misaligned_q   <= 1'b0;
            illegal_q      <= 1'b0;
            retire_count_q <= '0;
        end else begin
            state_q        <= state_d;
            rd_q           <= rd_d;
            f3_q           <= f3_d;
            off_q          <= off_d;
            we_q           <= bypass_valid_o;
            sel_rd_q       <= bypass_rd_o;
            data_q         <= bypass_data_o;
            misaligned_q   <= misaligned_d;
            illegal_q      <= illegal_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign we_o           = we_q;
    assign sel_rd_o       = sel_rd_q;
    assign data_o         = data_q;
    assign misaligned_o   = misaligned_q;
    assign illegal_o      = illegal_q;
    assign retire_count_o = retire_count_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: an RV32/CNT_W=4 instance and an RV64 instance
// driven in turn from random and directed transactions against a reference model.
module tb_writeback_unit;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int K_WRITE   = 0;
    localparam int K_NOWRITE = 1;
    localparam int K_MIS     = 2;
    localparam int K_ILL     = 3;

    typedef struct {
        int          kind;
        logic [63:0] data;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cur;
    logic        valid;
    logic        flush;
    logic        memValid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] alu;
    logic [63:0] mem;

    logic        readyA, weA, bvA, misA, illA;
    logic [4:0]  selA, brdA;
    logic [31:0] dataA, bdataA;
    logic [3:0]  cntA;

    logic        readyB, weB, bvB, misB, illB;
    logic [4:0]  selB, brdB;
    logic [63:0] dataB, bdataB;
    logic [31:0] cntB;

    logic        oReady, oWe, oBv, oMis, oIll;
    logic [4:0]  oSel, oBrd;
    logic [63:0] oData, oBdata, oCnt;

    int          xlen;
    logic [63:0] cntMask;
    logic [63:0] expCnt;
    int          testsRun = 0;
    int          testsFailed = 0;

    logic [6:0]  opcTab [12] = '{OPC_LOAD, OPC_LOAD, OPC_LOAD, OPC_OP, OPC_OP_IMM,
                                 OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_STORE,
                                 OPC_BRANCH, OPC_SYSTEM};

    always #5 clk = ~clk;

    writeback_unit #(.XLEN(32), .CNT_W(4)) dutA (
        .clk(clk), .rst_n(rst_n), .valid_i(valid && !cur), .ready_o(readyA),
        .flush_i(flush), .instr_i(instr), .pc_i(pc[31:0]), .alu_result_i(alu[31:0]),
        .mem_data_i(mem[31:0]), .mem_valid_i(memValid), .sel_rd_o(selA), .we_o(weA),
        .data_o(dataA), .bypass_valid_o(bvA), .bypass_rd_o(brdA), .bypass_data_o(bdataA),
        .misaligned_o(misA), .illegal_o(illA), .retire_count_o(cntA)
    );

    writeback_unit #(.XLEN(64), .CNT_W(32)) dutB (
        .clk(clk), .rst_n(rst_n), .valid_i(valid && cur), .ready_o(readyB),
        .flush_i(flush), .instr_i(instr), .pc_i(pc), .alu_result_i(alu),
        .mem_data_i(mem), .mem_valid_i(memValid), .sel_rd_o(selB), .we_o(weB),
        .data_o(dataB), .bypass_valid_o(bvB), .bypass_rd_o(brdB), .bypass_data_o(bdataB),
        .misaligned_o(misB), .illegal_o(illB), .retire_count_o(cntB)
    );

    always_comb begin
        if (!cur) begin
            oReady = readyA; oWe = weA; oBv = bvA; oMis = misA; oIll = illA;
            oSel = selA; oBrd = brdA;
            oData = {32'd0, dataA}; oBdata = {32'd0, bdataA}; oCnt = {60'd0, cntA};
        end else begin
            oReady = readyB; oWe = weB; oBv = bvB; oMis = misB; oIll = illB;
            oSel = selB; oBrd = brdB;
            oData = dataB; oBdata = bdataB; oCnt = {32'd0, cntB};
        end
    end

    // Architectural result of one instruction, from the ISA rules alone.
    function automatic res_t refResult(input int xl, input logic [31:0] ins,
                                       input logic [63:0] p, input logic [63:0] a,
                                       input logic [63:0] m);
        res_t        r;
        logic [63:0] msk;
        logic [63:0] v;
        logic [63:0] fieldMask;
        logic [2:0]  f3;
        int          off;
        int          size;
        msk    = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        r.kind = K_NOWRITE;
        r.data = 64'd0;
        case (ins[6:0])
            OPC_LOAD: begin
                f3   = ins[14:12];
                size = 1 << f3[1:0];
                off  = int'(a % 64'(xl / 8));
                if (f3 == 3'b111 || (xl == 32 && (f3 == 3'b110 || f3 == 3'b011))) begin
                    r.kind = K_ILL;
                end else if (off % size != 0) begin
                    r.kind = K_MIS;
                end else begin
                    v = (m & msk) >> (8 * off);
                    if (size < 8) begin
                        fieldMask = (64'd1 << (8 * size)) - 64'd1;
                        v = v & fieldMask;
                        if (!f3[2] && v[8*size-1]) v = v | ~fieldMask;
                    end
                    r.kind = K_WRITE;
                    r.data = v & msk;
                end
            end
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                r.kind = K_WRITE;
                r.data = a & msk;
            end
            OPC_JAL, OPC_JALR: begin
                r.kind = K_WRITE;
                r.data = (p + 64'd4) & msk;
            end
            default: r.kind = K_NOWRITE;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] mkInstr(input logic [6:0] opc, input logic [4:0] rd,
                                            input logic [2:0] f3, input logic [16:0] hi);
        return {hi, f3, rd, opc};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBypass(input res_t r, input logic [4:0] rd, input bit fl);
        bit w;
        w = (r.kind == K_WRITE) && (rd != 5'd0) && !fl;
        checkOutput("bypassValid", 64'(oBv), 64'(w));
        checkOutput("bypassRd", 64'(oBrd), w ? 64'(rd) : 64'd0);
        checkOutput("bypassData", oBdata, w ? r.data : 64'd0);
    endtask

    task automatic checkRegs(input res_t r, input logic [4:0] rd, input bit fl);
        bit w;
        w = (r.kind == K_WRITE) && (rd != 5'd0) && !fl;
        if ((r.kind == K_WRITE || r.kind == K_NOWRITE) && !fl) expCnt = (expCnt + 64'd1) & cntMask;
        checkOutput("we", 64'(oWe), 64'(w));
        checkOutput("selRd", 64'(oSel), w ? 64'(rd) : 64'd0);
        checkOutput("data", oData, w ? r.data : 64'd0);
        checkOutput("misaligned", 64'(oMis), 64'((r.kind == K_MIS) && !fl));
        checkOutput("illegal", 64'(oIll), 64'(r.kind == K_ILL));
        checkOutput("retireCount", oCnt, expCnt);
    endtask

    // One handshake; loads may see their data 'delay' cycles after accept.
    task automatic applyStimulus(input logic [31:0] ins, input logic [63:0] p,
                                 input logic [63:0] a, input logic [63:0] m,
                                 input int delay, input bit doFlush);
        res_t       r;
        bit         waits;
        logic [4:0] rd;
        r     = refResult(xlen, ins, p, a, m);
        rd    = ins[11:7];
        waits = (ins[6:0] == OPC_LOAD) && (r.kind != K_ILL) && (delay > 0);
        instr = ins; pc = p; alu = a; valid = 1'b1; flush = 1'b0;
        mem      = waits ? {$urandom, $urandom} : m;
        memValid = !waits;
        @(negedge clk);
        checkOutput("ready", 64'(oReady), 64'd1);
        if (!waits) checkBypass(r, rd, 1'b0);
        step();
        valid = 1'b0; memValid = 1'b0;
        instr = $urandom; alu = {$urandom, $urandom};
        if (waits) begin
            checkOutput("waitWe", 64'(oWe), 64'd0);
            for (int k = 1; k <= delay; k++) begin
                if (k == delay) begin
                    mem = m; memValid = 1'b1; flush = doFlush;
                end else begin
                    mem = {$urandom, $urandom};
                end
                @(negedge clk);
                checkOutput("waitReady", 64'(oReady), 64'd0);
                if (k < delay) checkOutput("waitBypass", 64'(oBv), 64'd0);
                else checkBypass(r, rd, doFlush);
                step();
            end
            memValid = 1'b0; flush = 1'b0;
        end
        checkRegs(r, rd, waits && doFlush);
    endtask

    // Idle cycle with stray mem_valid/flush, which must be ignored.
    task automatic idleCycle();
        valid = 1'b0;
        memValid = $urandom_range(0, 1) == 1;
        flush = $urandom_range(0, 1) == 1;
        mem = {$urandom, $urandom};
        @(negedge clk);
        checkOutput("idleReady", 64'(oReady), 64'd1);
        checkOutput("idleBypass", 64'(oBv), 64'd0);
        step();
        memValid = 1'b0; flush = 1'b0;
        checkOutput("idleWe", 64'(oWe), 64'd0);
        checkOutput("idleMis", 64'(oMis), 64'd0);
        checkOutput("idleIll", 64'(oIll), 64'd0);
        checkOutput("idleCount", oCnt, expCnt);
    endtask

    task automatic randomTxn();
        logic [6:0] opc;
        logic [4:0] rd;
        opc = opcTab[$urandom_range(0, 11)];
        rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        applyStimulus(mkInstr(opc, rd, 3'($urandom), 17'($urandom)),
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(0, 3), $urandom_range(0, 5) == 0);
        if ($urandom_range(0, 4) == 0) idleCycle();
    endtask

    task automatic checkResetState(input string who);
        checkOutput({who, "RstWe"}, 64'(oWe), 64'd0);
        checkOutput({who, "RstSel"}, 64'(oSel), 64'd0);
        checkOutput({who, "RstData"}, oData, 64'd0);
        checkOutput({who, "RstMis"}, 64'(oMis), 64'd0);
        checkOutput({who, "RstIll"}, 64'(oIll), 64'd0);
        checkOutput({who, "RstCnt"}, oCnt, 64'd0);
        checkOutput({who, "RstReady"}, 64'(oReady), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] c0;
        rst_n = 1'b0; cur = 1'b0; valid = 1'b0; flush = 1'b0; memValid = 1'b0;
        instr = '0; pc = '0; alu = '0; mem = '0;
        #12;
        checkResetState("A");
        cur = 1'b1;
        #1;
        checkResetState("B");
        cur = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        xlen = 32; cntMask = 64'hF; expCnt = 64'd0;
        $display("[TB] RV32 instance, CNT_W=4");

        applyStimulus(mkInstr(OPC_OP, 5'd5, 3'd0, 17'd0), 64'd0, 64'h1234_5678, 64'd0, 0, 1'b0);
        checkOutput("opData", oData, 64'h1234_5678);
        checkOutput("opCount", oCnt, 64'd1);
        applyStimulus(mkInstr(OPC_JAL, 5'd1, 3'd0, 17'd0), 64'h0000_0FFC, 64'd0, 64'd0, 0, 1'b0);
        checkOutput("jalData", oData, 64'h0000_1000);
        applyStimulus(mkInstr(OPC_JAL, 5'd1, 3'd0, 17'd0), 64'hFFFF_FFFC, 64'd0, 64'd0, 0, 1'b0);
        checkOutput("jalWrap", oData, 64'd0);
        checkOutput("jalWrapWe", 64'(oWe), 64'd1);
        applyStimulus(mkInstr(OPC_LOAD, 5'd3, 3'b000, 17'd0), 64'd0, 64'h0000_1003, 64'h80AA_BBCC, 3, 1'b0);
        checkOutput("lbData", oData, 64'hFFFF_FF80);
        applyStimulus(mkInstr(OPC_LOAD, 5'd3, 3'b100, 17'd0), 64'd0, 64'h0000_1003, 64'h80AA_BBCC, 3, 1'b0);
        checkOutput("lbuData", oData, 64'h0000_0080);
        c0 = expCnt;
        applyStimulus(mkInstr(OPC_LOAD, 5'd4, 3'b010, 17'd0), 64'd0, 64'h0000_2002, 64'h1111_2222, 2, 1'b0);
        checkOutput("lwMisPulse", 64'(oMis), 64'd1);
        checkOutput("lwMisCount", oCnt, c0);
        idleCycle();
        applyStimulus(mkInstr(OPC_LOAD, 5'd6, 3'b001, 17'd0), 64'd0, 64'h0000_2002, 64'h7FFF_0001, 1, 1'b0);
        checkOutput("lhData", oData, 64'h0000_7FFF);
        c0 = expCnt;
        applyStimulus(mkInstr(OPC_LOAD, 5'd7, 3'b010, 17'd0), 64'd0, 64'h0000_3000, 64'hDEAD_BEEF, 2, 1'b1);
        checkOutput("flushCount", oCnt, c0);
        idleCycle();
        applyStimulus(mkInstr(OPC_LOAD, 5'd0, 3'b010, 17'd0), 64'd0, 64'h0000_3000, 64'hDEAD_BEEF, 1, 1'b0);
        checkOutput("rd0Count", oCnt, (c0 + 64'd1) & 64'hF);
        applyStimulus(mkInstr(OPC_LOAD, 5'd8, 3'b111, 17'd0), 64'd0, 64'd0, 64'd0, 2, 1'b0);
        checkOutput("illPulse", 64'(oIll), 64'd1);

        c0 = expCnt;
        for (int i = 0; i < 17; i++)
            applyStimulus(mkInstr(OPC_OP, 5'(i + 1), 3'd0, 17'd0), 64'd0, 64'(i), 64'd0, 0, 1'b0);
        checkOutput("cntWrap", oCnt, (c0 + 64'd1) & 64'hF);

        instr = mkInstr(OPC_LOAD, 5'd9, 3'b010, 17'd0); alu = 64'd0; valid = 1'b1; memValid = 1'b0;
        step();
        valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        expCnt = 64'd0;
        checkOutput("midRstReady", 64'(oReady), 64'd1);
        checkOutput("midRstCnt", oCnt, 64'd0);
        checkOutput("midRstWe", 64'(oWe), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        memValid = 1'b1; mem = 64'h1234_5678;
        step();
        memValid = 1'b0;
        checkOutput("lostLoadWe", 64'(oWe), 64'd0);
        checkOutput("lostLoadCnt", oCnt, 64'd0);

        for (int i = 0; i < 200; i++) randomTxn();

        cur = 1'b1; xlen = 64; cntMask = 64'hFFFF_FFFF; expCnt = 64'd0;
        $display("[TB] RV64 instance, CNT_W=32");
        applyStimulus(mkInstr(OPC_LOAD, 5'd10, 3'b110, 17'd0), 64'd0, 64'h0000_4000, 64'h0000_0000_FFFF_FFFF, 0, 1'b0);
        checkOutput("lwuData", oData, 64'h0000_0000_FFFF_FFFF);
        applyStimulus(mkInstr(OPC_LOAD, 5'd11, 3'b010, 17'd0), 64'd0, 64'h0000_4004, 64'h8000_0000_0000_0001, 2, 1'b0);
        checkOutput("lwHiData", oData, 64'hFFFF_FFFF_8000_0000);
        applyStimulus(mkInstr(OPC_LOAD, 5'd12, 3'b011, 17'd0), 64'd0, 64'h0000_4008, 64'hCAFE_F00D_1234_5678, 1, 1'b0);
        checkOutput("ldData", oData, 64'hCAFE_F00D_1234_5678);
        applyStimulus(mkInstr(OPC_LOAD, 5'd13, 3'b011, 17'd0), 64'd0, 64'h0000_400C, 64'h0, 1, 1'b0);
        checkOutput("ldMis", 64'(oMis), 64'd1);
        applyStimulus(mkInstr(OPC_JALR, 5'd1, 3'd0, 17'd0), 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 0, 1'b0);
        checkOutput("jalrWrap64", oData, 64'd0);

        for (int i = 0; i < 200; i++) randomTxn();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
